// File: rtl/game_sequencer.sv
// Mastermind-style turn sequencer: snapshot a guess, score it in 14 cycles (store, 4 exact, 8 colour, result).
// Buttons are dropped while scoring is busy; all outputs are registered.
module game_sequencer #(
  parameter int MAX_TURNS = 8,
  parameter int COLOR_W   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_select,
  input  logic               btn_mode,
  input  logic [COLOR_W-1:0] guess3,
  input  logic [COLOR_W-1:0] guess2,
  input  logic [COLOR_W-1:0] guess1,
  input  logic [COLOR_W-1:0] guess0,
  input  logic [COLOR_W-1:0] secret3,
  input  logic [COLOR_W-1:0] secret2,
  input  logic [COLOR_W-1:0] secret1,
  input  logic [COLOR_W-1:0] secret0,
  output logic               mode,
  output logic               store,
  output logic               new_game,
  output logic [3:0]         turn,
  output logic [2:0]         exact,
  output logic [2:0]         partial,
  output logic               score_valid,
  output logic               busy,
  output logic               win,
  output logic               lose
);

  localparam logic [2:0] ENTRY     = 3'd0;
  localparam logic [2:0] CAPTURE   = 3'd1;
  localparam logic [2:0] SCORE_EX  = 3'd2;
  localparam logic [2:0] SCORE_COL = 3'd3;
  localparam logic [2:0] RESULT    = 3'd4;
  localparam logic [2:0] BROWSE    = 3'd5;
  localparam logic [2:0] WIN       = 3'd6;
  localparam logic [2:0] LOSE      = 3'd7;

  // Colour index is 3 bits (8 scoring cycles); widen both sides for the compare.
  localparam int CW = (COLOR_W > 3) ? COLOR_W : 3;

  logic [2:0]                state;
  logic [3:0][COLOR_W-1:0]   g_snap;
  logic [3:0][COLOR_W-1:0]   s_snap;
  logic [2:0]                idx;
  logic [2:0]                exact_acc;
  logic [2:0]                common_acc;

  logic                      peg_match;
  logic [2:0]                g_cnt;
  logic [2:0]                s_cnt;
  logic [2:0]                col_min;
  logic [3:0]                turn_inc;

  assign peg_match = (g_snap[idx[1:0]] == s_snap[idx[1:0]]);
  assign turn_inc  = turn + 4'd1;

  // Occurrences of colour idx in each snapshot; the smaller count is the common overlap.
  always_comb begin
    g_cnt = 3'd0;
    s_cnt = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (CW'(g_snap[i]) == CW'(idx)) g_cnt = g_cnt + 3'd1;
      if (CW'(s_snap[i]) == CW'(idx)) s_cnt = s_cnt + 3'd1;
    end
    col_min = (g_cnt < s_cnt) ? g_cnt : s_cnt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ENTRY;
      g_snap      <= '0;
      s_snap      <= '0;
      idx         <= 3'd0;
      exact_acc   <= 3'd0;
      common_acc  <= 3'd0;
      mode        <= 1'b0;
      store       <= 1'b0;
      new_game    <= 1'b0;
      turn        <= 4'd0;
      exact       <= 3'd0;
      partial     <= 3'd0;
      score_valid <= 1'b0;
      busy        <= 1'b0;
      win         <= 1'b0;
      lose        <= 1'b0;
    end else begin
      store    <= 1'b0;
      new_game <= 1'b0;
      case (state)
        ENTRY: begin
          if (btn_select) begin
            g_snap      <= {guess3, guess2, guess1, guess0};
            s_snap      <= {secret3, secret2, secret1, secret0};
            idx         <= 3'd0;
            exact_acc   <= 3'd0;
            common_acc  <= 3'd0;
            store       <= 1'b1;
            busy        <= 1'b1;
            score_valid <= 1'b0;
            state       <= CAPTURE;
          end else if (btn_mode && (turn != 4'd0)) begin
            mode  <= 1'b1;
            state <= BROWSE;
          end
        end
        CAPTURE: begin
          idx   <= 3'd0;
          state <= SCORE_EX;
        end
        SCORE_EX: begin
          exact_acc <= exact_acc + {2'b00, peg_match};
          if (idx == 3'd3) begin
            idx   <= 3'd0;
            state <= SCORE_COL;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        SCORE_COL: begin
          common_acc <= common_acc + col_min;
          if (idx == 3'd7) begin
            idx   <= 3'd0;
            state <= RESULT;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        RESULT: begin
          exact       <= exact_acc;
          partial     <= common_acc - exact_acc;
          score_valid <= 1'b1;
          turn        <= turn_inc;
          busy        <= 1'b0;
          // A full match wins even when it lands on the last allowed turn.
          if (exact_acc == 3'd4) begin
            win   <= 1'b1;
            state <= WIN;
          end else if (turn_inc == 4'(MAX_TURNS)) begin
            lose  <= 1'b1;
            state <= LOSE;
          end else begin
            state <= ENTRY;
          end
        end
        BROWSE: begin
          if (btn_mode) begin
            mode  <= 1'b0;
            state <= ENTRY;
          end
        end
        WIN, LOSE: begin
          if (btn_select) begin
            new_game    <= 1'b1;
            turn        <= 4'd0;
            exact       <= 3'd0;
            partial     <= 3'd0;
            score_valid <= 1'b0;
            win         <= 1'b0;
            lose        <= 1'b0;
            mode        <= 1'b0;
            state       <= ENTRY;
          end else if (btn_mode) begin
            mode <= ~mode;
          end
        end
        default: state <= ENTRY;
      endcase
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with a scoreboard of expected scores per turn.
module tb_game_sequencer;

  localparam int MAX_TURNS = 8;
  localparam int COLOR_W   = 3;

  logic               clk = 1'b0;
  logic               reset;
  logic               btn_select;
  logic               btn_mode;
  logic [COLOR_W-1:0] guess3, guess2, guess1, guess0;
  logic [COLOR_W-1:0] secret3, secret2, secret1, secret0;
  logic               mode, store, new_game, score_valid, busy, win, lose;
  logic [3:0]         turn;
  logic [2:0]         exact, partial;

  game_sequencer #(.MAX_TURNS(MAX_TURNS), .COLOR_W(COLOR_W)) dut (
    .clk(clk), .reset(reset), .btn_select(btn_select), .btn_mode(btn_mode),
    .guess3(guess3), .guess2(guess2), .guess1(guess1), .guess0(guess0),
    .secret3(secret3), .secret2(secret2), .secret1(secret1), .secret0(secret0),
    .mode(mode), .store(store), .new_game(new_game), .turn(turn),
    .exact(exact), .partial(partial), .score_valid(score_valid),
    .busy(busy), .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ex;
    int pa;
    int tn;
    bit w;
    bit l;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   store_cnt = 0;
  int   ng_cnt = 0;
  int   exp_store = 0;
  int   exp_ng = 0;
  int   tn = 0;

  // Count one-cycle pulses mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (store) store_cnt++;
    if (new_game) ng_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Independent reference: mark exact pegs, then pair leftover pegs greedily.
  function automatic void score_model(input logic [3:0][2:0] g, input logic [3:0][2:0] s,
                                      output int ex, output int pa);
    bit gu[4];
    bit su[4];
    ex = 0;
    pa = 0;
    for (int i = 0; i < 4; i++) begin
      gu[i] = 1'b0;
      su[i] = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      if (g[i] == s[i]) begin
        ex++;
        gu[i] = 1'b1;
        su[i] = 1'b1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (!gu[i]) begin
        for (int j = 0; j < 4; j++) begin
          if (!su[j] && g[i] == s[j]) begin
            su[j] = 1'b1;
            pa++;
            break;
          end
        end
      end
    end
  endfunction

  task automatic run_turn(input logic [3:0][2:0] g, input logic [3:0][2:0] s, input bit with_mode);
    exp_t e;
    int   ex, pa;
    score_model(g, s, ex, pa);
    tn++;
    e.ex = ex; e.pa = pa; e.tn = tn;
    e.w  = (ex == 4);
    e.l  = (ex != 4) && (tn == MAX_TURNS);
    sb.push_back(e);

    guess0 = g[0]; guess1 = g[1]; guess2 = g[2]; guess3 = g[3];
    secret0 = s[0]; secret1 = s[1]; secret2 = s[2]; secret3 = s[3];
    btn_select = 1'b1;
    btn_mode   = with_mode;
    tick();
    btn_select = 1'b0;
    btn_mode   = 1'b0;
    exp_store++;
    check("store_pulse", store, 1);
    check("busy_set", busy, 1);
    check("sv_clear", score_valid, 0);
    // Scramble the live inputs; scoring must use the snapshot.
    guess0 = 3'($urandom_range(7)); guess1 = 3'($urandom_range(7));
    guess2 = 3'($urandom_range(7)); guess3 = 3'($urandom_range(7));
    secret0 = 3'($urandom_range(7)); secret1 = 3'($urandom_range(7));
    secret2 = 3'($urandom_range(7)); secret3 = 3'($urandom_range(7));
    tick();
    check("store_once", store, 0);
    for (int k = 2; k <= 13; k++) begin
      if (k == 5) begin
        btn_select = 1'b1;
        btn_mode   = 1'b1;
      end
      tick();
      btn_select = 1'b0;
      btn_mode   = 1'b0;
    end
    check("sv_before_14", score_valid, 0);
    check("busy_before_14", busy, 1);
    tick();
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_empty: observed 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      check("exact", exact, e.ex);
      check("partial", partial, e.pa);
      check("turn", turn, e.tn);
      check("win", win, e.w);
      check("lose", lose, e.l);
    end
    check("score_valid", score_valid, 1);
    check("busy_clear", busy, 0);
    check("mode_entry", mode, 0);
    check("store_count", store_cnt, exp_store);
  endtask

  task automatic rand_nonwin(output logic [3:0][2:0] g, output logic [3:0][2:0] s);
    for (int i = 0; i < 4; i++) begin
      g[i] = 3'($urandom_range(7));
      s[i] = 3'($urandom_range(7));
    end
    if (g == s) g[0] = g[0] + 3'd1;
  endtask

  task automatic press_new_game(input string tag);
    btn_select = 1'b1;
    tick();
    btn_select = 1'b0;
    exp_ng++;
    check({tag, "_new_game"}, new_game, 1);
    check({tag, "_no_store"}, store, 0);
    check({tag, "_turn0"}, turn, 0);
    check({tag, "_win0"}, win, 0);
    check({tag, "_lose0"}, lose, 0);
    check({tag, "_sv0"}, score_valid, 0);
    tick();
    check({tag, "_ng_once"}, new_game, 0);
    check({tag, "_ng_count"}, ng_cnt, exp_ng);
    check({tag, "_store_count"}, store_cnt, exp_store);
    tn = 0;
  endtask

  initial begin
    logic [3:0][2:0] g;
    logic [3:0][2:0] s;
    reset = 1'b0;
    btn_select = 1'b0;
    btn_mode = 1'b0;
    {guess3, guess2, guess1, guess0} = '0;
    {secret3, secret2, secret1, secret0} = '0;
    tick(); tick(); tick();
    check("rst_outputs", {mode, store, new_game, turn, exact, partial, score_valid, busy, win, lose}, 0);
    @(negedge clk);
    reset = 1'b1;
    tick(); tick(); tick();
    check("rst_release_store", store_cnt, 0);
    check("rst_release_ng", ng_cnt, 0);

    // Mode button is ignored before any guess has been scored.
    btn_mode = 1'b1;
    tick();
    btn_mode = 1'b0;
    tick();
    check("mode_turn0", mode, 0);

    // guess0..3 = 1,2,4,3 against secret 1,2,3,4
    g = {3'd3, 3'd4, 3'd2, 3'd1};
    s = {3'd4, 3'd3, 3'd2, 3'd1};
    run_turn(g, s, 1'b0);
    // secret 5,5,1,2 against guess 5,1,5,5
    g = {3'd5, 3'd5, 3'd1, 3'd5};
    s = {3'd2, 3'd1, 3'd5, 3'd5};
    run_turn(g, s, 1'b0);

    btn_mode = 1'b1;
    tick();
    btn_mode = 1'b0;
    check("browse_enter", mode, 1);
    btn_select = 1'b1;
    tick();
    btn_select = 1'b0;
    tick();
    check("browse_sel_ignored", store_cnt, exp_store);
    check("browse_busy", busy, 0);
    check("browse_mode_held", mode, 1);
    btn_mode = 1'b1;
    tick();
    btn_mode = 1'b0;
    check("browse_exit", mode, 0);

    // Turn 3: exact match, with btn_mode pressed alongside btn_select.
    g = {3'd7, 3'd0, 3'd6, 3'd2};
    run_turn(g, g, 1'b1);
    btn_mode = 1'b1;
    tick();
    btn_mode = 1'b0;
    check("win_browse_mode", mode, 1);
    check("win_held", win, 1);
    btn_mode = 1'b1;
    tick();
    btn_mode = 1'b0;
    check("win_browse_back", mode, 0);
    press_new_game("win_ng");

    // Eight misses end the game in LOSE.
    for (int t = 0; t < MAX_TURNS; t++) begin
      rand_nonwin(g, s);
      run_turn(g, s, 1'b0);
    end
    check("lose_turn_cap", turn, MAX_TURNS);
    press_new_game("lose_ng");

    // A match on the final turn must win, not lose.
    for (int t = 0; t < MAX_TURNS - 1; t++) begin
      rand_nonwin(g, s);
      run_turn(g, s, 1'b0);
    end
    g = {3'd1, 3'd1, 3'd4, 3'd4};
    run_turn(g, g, 1'b0);
    press_new_game("final_win_ng");

    // Reset asserted five cycles into scoring aborts the turn.
    g = {3'd3, 3'd2, 3'd1, 3'd0};
    guess0 = g[0]; guess1 = g[1]; guess2 = g[2]; guess3 = g[3];
    secret0 = g[0]; secret1 = g[1]; secret2 = g[2]; secret3 = g[3];
    btn_select = 1'b1;
    tick();
    btn_select = 1'b0;
    exp_store++;
    repeat (5) tick();
    check("abort_busy_before", busy, 1);
    reset = 1'b0;
    #1;
    check("abort_outputs", {mode, store, new_game, turn, exact, partial, score_valid, busy, win, lose}, 0);
    tick(); tick();
    @(negedge clk);
    reset = 1'b1;
    repeat (20) tick();
    check("abort_store_count", store_cnt, exp_store);
    check("abort_ng_count", ng_cnt, exp_ng);
    check("abort_turn", turn, 0);
    check("abort_sv", score_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_win", win, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter MAX_TURNS, default 8, meaning guesses allowed per game (1..8).
REQ-002 SHALL have parameter COLOR_W, default 3, meaning bits per peg colour.
REQ-003 SHALL have ports: clk  in  1  system clock, all state changes on rising edge.
REQ-004 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: btn_select, btn_mode  in  1 each  one-cycle debounced button pulses.
REQ-006 SHALL have ports: guess3..guess0  in  COLOR_W each  current peg entry; secret3..secret0  in  COLOR_W each  code to break.
REQ-007 SHALL have ports: mode  out  1  0=guess entry, 1=history browse, feeds history block.
REQ-008 SHALL have ports: store  out  1  one-cycle pulse commanding history to record the guess.
REQ-009 SHALL have ports: new_game  out  1  one-cycle pulse clearing history.
REQ-010 SHALL have ports: turn  out  4  completed guesses; exact, partial  out  3 each  last score; score_valid  out  1.
REQ-011 SHALL have ports: busy  out  1  scoring in progress; win, lose  out  1 each  terminal flags.

Function
REQ-012 SHALL implement states ENTRY, CAPTURE, SCORE_EX, SCORE_COL, RESULT, BROWSE, WIN, LOSE; all outputs registered.
REQ-013 In ENTRY, btn_select SHALL snapshot guess0..3 and secret0..3 into internal registers and move to CAPTURE; later input changes SHALL not affect scoring.
REQ-014 CAPTURE SHALL assert store for exactly one cycle, then move to SCORE_EX.
REQ-015 SCORE_EX SHALL take 4 cycles, one peg index 0..3 per cycle, counting positions where snapshot guess equals secret.
REQ-016 SCORE_COL SHALL take 8 cycles, one colour 0..7 per cycle, accumulating min(count in guess, count in secret).
REQ-017 RESULT SHALL write exact, partial = common - exact, set score_valid=1, increment turn, in one cycle.
REQ-018 Outputs from RESULT SHALL be visible after the 14th rising edge following the edge sampling btn_select.
REQ-019 After RESULT: exact==4 -> WIN; else turn==MAX_TURNS -> LOSE; else ENTRY. Win SHALL take priority on the final turn.
REQ-020 busy SHALL be 1 in CAPTURE, SCORE_EX, SCORE_COL, RESULT, else 0; all buttons ignored while busy.
REQ-021 score_valid SHALL clear on the edge leaving ENTRY via btn_select and hold otherwise.
REQ-022 In ENTRY, btn_mode with turn>0 SHALL move to BROWSE (mode=1); with turn==0 it SHALL be ignored.
REQ-023 In BROWSE, btn_mode SHALL return to ENTRY (mode=0); btn_select SHALL be ignored.
REQ-024 btn_select and btn_mode in the same ENTRY cycle: btn_select SHALL win, btn_mode dropped.
REQ-025 In WIN/LOSE, btn_mode SHALL toggle mode (browse allowed, win/lose held); btn_select SHALL pulse new_game one cycle, clear turn, exact, partial, score_valid, win, lose, mode and go to ENTRY.
REQ-026 turn SHALL never exceed MAX_TURNS; exact and partial SHALL each be 0..4 with exact+partial<=4.

Reset
REQ-027 reset low SHALL immediately force ENTRY, mode=0, store=0, new_game=0, turn=0, exact=0, partial=0, score_valid=0, busy=0, win=0, lose=0, clearing snapshots and counters.
REQ-028 reset asserted mid-scoring SHALL abort the score with no turn increment and no further store pulse.
REQ-029 Leaving reset SHALL not generate store or new_game pulses.

Verification
REQ-030 Secret 1,2,3,4, guess 1,2,4,3, btn_select -> store one pulse next cycle; after 14 edges exact=2, partial=2, turn=1, score_valid=1.
REQ-031 Secret 5,5,1,2, guess 5,1,5,5 -> exact=1, partial=2 (duplicate colours not double-counted).
REQ-032 Secret equals guess on turn 3 -> exact=4, win=1, state WIN; btn_select -> new_game pulse, turn=0, win=0.
REQ-033 MAX_TURNS=8, eight non-winning guesses -> lose=1 after eighth RESULT; ninth btn_select -> new_game, not store.
REQ-034 btn_mode at turn=0 -> mode stays 0; at turn=2 -> mode=1, btn_select ignored, btn_mode -> mode=0.
REQ-035 reset low 5 cycles into scoring -> all outputs zero, turn unchanged at 0, no store pulse after release.
